// File: rtl/btb_wrbuf_pkg.sv
// Occupancy classification for the BTB write buffer; derived purely from count.
package btb_wrbuf_pkg;
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input int unsigned count, input int unsigned entries);
    if (count == 0)            return OCC_EMPTY;
    else if (count == entries) return OCC_FULL;
    else                       return OCC_PARTIAL;
  endfunction
endpackage

// File: rtl/config_pkg.sv
// Configuration shared by the BTB and its write buffer: datapath width and the
// {class, target} record stored per table entry.
package config_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [3:0]      iclass;
    logic [XLEN-1:0] target;
  } btb_upd_t;
endpackage

// File: rtl/btb_wrbuf_if.sv
// Pipeline-side bundle of the BTB write buffer: M-stage update, table write port
// and F-stage forwarding lookup. The slave modport is the buffer's view.
interface btb_wrbuf_if
  import config_pkg::*;
#(
  parameter int Depth = 10
);
  logic             StallW;
  logic             FlushW;
  logic             UpdValidM;
  logic [Depth-1:0] UpdIdxM;
  logic [3:0]       UpdClassM;
  logic [XLEN-1:0]  UpdTargetM;
  logic             BufFullM;
  logic             WrValid;
  logic [Depth-1:0] WrIdx;
  btb_upd_t         WrData;
  logic             WrReady;
  logic [Depth-1:0] LookupIdxF;
  logic             LookupHit;
  btb_upd_t         LookupData;

  modport slave (
    input  StallW, FlushW, UpdValidM, UpdIdxM, UpdClassM, UpdTargetM,
    input  WrReady, LookupIdxF,
    output BufFullM, WrValid, WrIdx, WrData, LookupHit, LookupData
  );

  modport master (
    output StallW, FlushW, UpdValidM, UpdIdxM, UpdClassM, UpdTargetM,
    output WrReady, LookupIdxF,
    input  BufFullM, WrValid, WrIdx, WrData, LookupHit, LookupData
  );
endinterface

// File: rtl/btb_wrbuf_cam.sv
// Index match across all buffer slots with youngest-entry priority; the youngest
// is the match furthest from head in queue order.
module btb_wrbuf_cam #(
  parameter  int Depth   = 10,
  parameter  int Entries = 4,
  localparam int PW      = $clog2(Entries)
) (
  input  logic [Entries-1:0]            valid_i,
  input  logic [Entries-1:0][Depth-1:0] idx_i,
  input  logic [Depth-1:0]              key_i,
  input  logic [PW-1:0]                 head_i,
  output logic                          hit_o,
  output logic [PW-1:0]                 sel_o
);
  logic [Entries-1:0] match;
  logic [PW-1:0]      pos;

  generate
    for (genvar gi = 0; gi < Entries; gi++) begin : g_match
      assign match[gi] = valid_i[gi] && (idx_i[gi] == key_i);
    end
  endgenerate

  always_comb begin
    hit_o = |match;
    sel_o = '0;
    pos   = '0;
    // Walk oldest to youngest so the last match seen wins.
    for (int off = 0; off < Entries; off++) begin
      pos = head_i + PW'(off);
      if (match[pos]) sel_o = pos;
    end
  end
endmodule

// File: rtl/btb_wrbuf.sv
// Coalescing FIFO between BTB mispredict updates and the single table write port,
// with combinational forwarding of buffered entries to the fetch-stage lookup.
module btb_wrbuf
  import config_pkg::*;
  import btb_wrbuf_pkg::*;
#(
  parameter int Depth   = 10,
  parameter int Entries = 4
) (
  input  logic       clk,
  input  logic       reset,
  btb_wrbuf_if.slave bus
);
  localparam int PW = $clog2(Entries);
  localparam int CW = PW + 1;

  logic [Entries-1:0]            valid_q, valid_d;
  logic [Entries-1:0][Depth-1:0] idx_q, idx_d;
  btb_upd_t [Entries-1:0]        data_q, data_d;
  logic [PW-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                 count_q, count_d;

  occ_e               occ;
  logic               wr_valid, deq, buf_full, enq, append;
  logic [Entries-1:0] leave_mask;
  logic               coal_hit, lk_hit;
  logic [PW-1:0]      coal_sel, lk_sel;
  btb_upd_t           upd;

  assign occ        = occ_of(32'(count_q), 32'(Entries));
  assign wr_valid   = (occ != OCC_EMPTY);
  assign deq        = wr_valid & bus.WrReady;
  assign buf_full   = (occ == OCC_FULL) & ~deq;
  assign enq        = bus.UpdValidM & ~bus.StallW & ~bus.FlushW & ~buf_full;
  assign upd        = '{iclass: bus.UpdClassM, target: bus.UpdTargetM};
  // The departing head cannot absorb a coalesce; the update must re-append.
  assign leave_mask = deq ? (Entries'(1) << head_q) : '0;
  assign append     = enq & ~coal_hit;

  btb_wrbuf_cam #(.Depth(Depth), .Entries(Entries)) u_cam_coal (
    .valid_i (valid_q & ~leave_mask),
    .idx_i   (idx_q),
    .key_i   (bus.UpdIdxM),
    .head_i  (head_q),
    .hit_o   (coal_hit),
    .sel_o   (coal_sel)
  );

  btb_wrbuf_cam #(.Depth(Depth), .Entries(Entries)) u_cam_lookup (
    .valid_i (valid_q),
    .idx_i   (idx_q),
    .key_i   (bus.LookupIdxF),
    .head_i  (head_q),
    .hit_o   (lk_hit),
    .sel_o   (lk_sel)
  );

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (enq && coal_hit) begin
      data_d[coal_sel] = upd;
    end
    // Applied after the dequeue so a full-buffer append into the freed slot wins.
    if (append) begin
      valid_d[tail_q] = 1'b1;
      idx_d[tail_q]   = bus.UpdIdxM;
      data_d[tail_q]  = upd;
      tail_d          = tail_q + PW'(1);
    end
    case ({append, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign bus.BufFullM   = buf_full;
  assign bus.WrValid    = wr_valid;
  assign bus.WrIdx      = wr_valid ? idx_q[head_q] : '0;
  assign bus.WrData     = wr_valid ? data_q[head_q] : '0;
  assign bus.LookupHit  = lk_hit;
  assign bus.LookupData = lk_hit ? data_q[lk_sel] : '0;
endmodule

// File: tb/tb_btb_wrbuf.sv
// Directed bench for btb_wrbuf: enqueue/dequeue, full handling, coalescing,
// stall/flush blocking and asynchronous reset mid-drain.
module tb_btb_wrbuf;
  import config_pkg::*;

  localparam int Depth   = 10;
  localparam int Entries = 4;

  logic clk;
  logic reset;

  btb_wrbuf_if #(.Depth(Depth)) bus ();

  btb_wrbuf #(.Depth(Depth), .Entries(Entries)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [Depth-1:0] drained_idx[$];
  logic [35:0]      drained_data[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] rec(input logic [3:0] cls, input logic [31:0] tgt);
    return {cls, tgt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle update request; inputs are released right after the edge.
  task automatic enq(input logic [Depth-1:0] idx, input logic [3:0] cls,
                     input logic [31:0] tgt, input logic rdy);
    bus.UpdValidM  = 1'b1;
    bus.UpdIdxM    = idx;
    bus.UpdClassM  = cls;
    bus.UpdTargetM = tgt;
    bus.WrReady    = rdy;
    $display("txn enq idx=%h cls=%h tgt=%h rdy=%0b", idx, cls, tgt, rdy);
    step();
    bus.UpdValidM  = 1'b0;
    bus.WrReady    = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    logic done;
    done = 1'b0;
    drained_idx.delete();
    drained_data.delete();
    bus.WrReady = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (!bus.WrValid) begin
        done = 1'b1;
        break;
      end
      drained_idx.push_back(bus.WrIdx);
      drained_data.push_back(bus.WrData);
      $display("txn write idx=%h data=%h", bus.WrIdx, bus.WrData);
      step();
    end
    bus.WrReady = 1'b0;
    check_eq("drain_bound", {63'd0, done}, 64'd1);
  endtask

  initial begin
    reset          = 1'b0;
    bus.StallW     = 1'b0;
    bus.FlushW     = 1'b0;
    bus.UpdValidM  = 1'b0;
    bus.UpdIdxM    = '0;
    bus.UpdClassM  = '0;
    bus.UpdTargetM = '0;
    bus.WrReady    = 1'b0;
    bus.LookupIdxF = '0;
    step();
    step();
    check_eq("rst_wrvalid", {63'd0, bus.WrValid}, 64'd0);
    check_eq("rst_full", {63'd0, bus.BufFullM}, 64'd0);
    check_eq("rst_hit", {63'd0, bus.LookupHit}, 64'd0);
    check_eq("rst_wridx", {54'd0, bus.WrIdx}, 64'd0);
    check_eq("rst_wrdata", {28'd0, bus.WrData}, 64'd0);
    check_eq("rst_lkdata", {28'd0, bus.LookupData}, 64'd0);
    reset = 1'b1;
    step();
    check_eq("rel_wrvalid", {63'd0, bus.WrValid}, 64'd0);

    // Single enqueue is visible one cycle later on both views.
    enq(10'h005, 4'b0001, 32'h8000_0040, 1'b0);
    bus.LookupIdxF = 10'h005;
    #1;
    check_eq("e1_wrvalid", {63'd0, bus.WrValid}, 64'd1);
    check_eq("e1_wridx", {54'd0, bus.WrIdx}, 64'h005);
    check_eq("e1_wrdata", {28'd0, bus.WrData}, {28'd0, rec(4'b0001, 32'h8000_0040)});
    check_eq("e1_hit", {63'd0, bus.LookupHit}, 64'd1);
    check_eq("e1_lkdata", {28'd0, bus.LookupData}, {28'd0, rec(4'b0001, 32'h8000_0040)});
    bus.LookupIdxF = 10'h006;
    #1;
    check_eq("e1_miss", {63'd0, bus.LookupHit}, 64'd0);
    drain(8);
    check_eq("e1_drain_n", 64'(drained_idx.size()), 64'd1);

    // Fill, reject while full, then simultaneous enqueue+dequeue at full.
    for (int i = 1; i <= 4; i++) enq(10'h010 + 10'(i), 4'h2, 32'h100 + 32'(i), 1'b0);
    check_eq("full_flag", {63'd0, bus.BufFullM}, 64'd1);
    enq(10'h015, 4'h2, 32'h105, 1'b0);
    bus.LookupIdxF = 10'h015;
    #1;
    check_eq("full_reject", {63'd0, bus.LookupHit}, 64'd0);
    check_eq("full_head", {54'd0, bus.WrIdx}, 64'h011);
    bus.WrReady = 1'b1;
    #1;
    check_eq("full_deq_accept", {63'd0, bus.BufFullM}, 64'd0);
    enq(10'h016, 4'h3, 32'h106, 1'b1);
    bus.LookupIdxF = 10'h016;
    #1;
    check_eq("full_head2", {54'd0, bus.WrIdx}, 64'h012);
    check_eq("full_still", {63'd0, bus.BufFullM}, 64'd1);
    check_eq("full_new_hit", {63'd0, bus.LookupHit}, 64'd1);
    bus.LookupIdxF = 10'h011;
    #1;
    check_eq("full_old_gone", {63'd0, bus.LookupHit}, 64'd0);
    drain(8);
    check_eq("full_drain_n", 64'(drained_idx.size()), 64'd4);
    if (drained_idx.size() == 4) begin
      check_eq("full_order0", {54'd0, drained_idx[0]}, 64'h012);
      check_eq("full_order3", {54'd0, drained_idx[3]}, 64'h016);
    end

    // Coalesce into a resident entry that is not leaving.
    enq(10'h010, 4'h4, 32'h0000_A0A0, 1'b0);
    enq(10'h010, 4'h5, 32'h0000_B0B0, 1'b0);
    check_eq("coal_data", {28'd0, bus.WrData}, {28'd0, rec(4'h5, 32'h0000_B0B0)});
    drain(8);
    check_eq("coal_n", 64'(drained_idx.size()), 64'd1);

    // Matching head is leaving: old value written, new one re-appended.
    enq(10'h010, 4'h4, 32'h0000_A0A0, 1'b0);
    bus.WrReady = 1'b1;
    #1;
    check_eq("hl_old_write", {28'd0, bus.WrData}, {28'd0, rec(4'h4, 32'h0000_A0A0)});
    enq(10'h010, 4'h6, 32'h0000_C0C0, 1'b1);
    check_eq("hl_new_head", {28'd0, bus.WrData}, {28'd0, rec(4'h6, 32'h0000_C0C0)});
    drain(8);
    check_eq("hl_n", 64'(drained_idx.size()), 64'd1);

    // Head leaving while a younger entry with the same index is coalesced.
    enq(10'h020, 4'h1, 32'h0000_2000, 1'b0);
    enq(10'h021, 4'h1, 32'h0000_2100, 1'b0);
    enq(10'h021, 4'h7, 32'h0000_2177, 1'b1);
    drain(8);
    check_eq("cy_n", 64'(drained_idx.size()), 64'd1);
    if (drained_data.size() == 1)
      check_eq("cy_data", {28'd0, drained_data[0]}, {28'd0, rec(4'h7, 32'h0000_2177)});

    // Flush and stall block enqueue but keep contents.
    enq(10'h030, 4'h8, 32'h0000_3000, 1'b0);
    bus.FlushW = 1'b1;
    enq(10'h031, 4'h8, 32'h0000_3100, 1'b0);
    bus.FlushW = 1'b0;
    bus.StallW = 1'b1;
    enq(10'h030, 4'h9, 32'h0000_3999, 1'b0);
    bus.StallW = 1'b0;
    bus.LookupIdxF = 10'h031;
    #1;
    check_eq("flush_blocked", {63'd0, bus.LookupHit}, 64'd0);
    check_eq("stall_kept", {28'd0, bus.WrData}, {28'd0, rec(4'h8, 32'h0000_3000)});
    drain(8);
    check_eq("fs_n", 64'(drained_idx.size()), 64'd1);

    // Asynchronous reset in the middle of a drain.
    enq(10'h040, 4'h1, 32'h0000_4000, 1'b0);
    enq(10'h041, 4'h1, 32'h0000_4100, 1'b0);
    enq(10'h042, 4'h1, 32'h0000_4200, 1'b0);
    bus.LookupIdxF = 10'h041;
    bus.WrReady    = 1'b1;
    #1;
    check_eq("pre_rst_hit", {63'd0, bus.LookupHit}, 64'd1);
    #2;
    reset = 1'b0;
    $display("txn async reset asserted");
    #1;
    check_eq("ar_wrvalid", {63'd0, bus.WrValid}, 64'd0);
    check_eq("ar_hit", {63'd0, bus.LookupHit}, 64'd0);
    check_eq("ar_full", {63'd0, bus.BufFullM}, 64'd0);
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("post_rst_nowrite", {63'd0, bus.WrValid}, 64'd0);
    end
    check_eq("post_rst_hit", {63'd0, bus.LookupHit}, 64'd0);
    bus.WrReady = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
